// File: rtl/spi_boot_loader.sv
// spi_boot_loader: copies a length-prefixed firmware image from SPI flash into TCM over AXI, then releases the CPU.
// Define SPI_BOOT_CHECKSUM_EN to require a trailing mod-2^32 checksum word before release.
module spi_boot_loader #(
  parameter logic [23:0] FLASH_OFFSET = 24'h100000,
  parameter logic [31:0] TCM_BASE = 32'h00000000,
  parameter int MAX_WORDS = 4096,
  parameter int SCK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_miso_i,
  output logic        spi_clk_o,
  output logic        spi_mosi_o,
  output logic        spi_cs_o,
  output logic        mem_awvalid_o,
  output logic [31:0] mem_awaddr_o,
  output logic [3:0]  mem_awid_o,
  output logic [7:0]  mem_awlen_o,
  output logic [1:0]  mem_awburst_o,
  output logic        mem_wvalid_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        mem_wlast_o,
  output logic        mem_bready_o,
  input  logic        mem_awready_i,
  input  logic        mem_wready_i,
  input  logic        mem_bvalid_i,
  input  logic [1:0]  mem_bresp_i,
  output logic        rst_cpu_o,
  output logic        done_o,
  output logic        error_o
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int DW = SCK_DIV > 1 ? $clog2(SCK_DIV) : 1;
  typedef enum logic [3:0] {IDLE, CMD, HDR, DATA, AXI, RESP, CHK, DONE, ERROR} state_t;
`ifdef SPI_BOOT_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state_q, state_d;
  logic [DW-1:0] div_q;
  logic sck_q, aw_q, w_q;
  logic [4:0] bit_q;
  logic [31:0] tx_q, rx_q, addr_q, data_q;
  logic [CW-1:0] n_q, k_q;
`ifdef SPI_BOOT_CHECKSUM_EN
  logic [31:0] sum_q;
`endif
  logic spi_on, tick, word_done, last, bad_len;
  logic [31:0] word;
  always_comb begin
    spi_on = state_q inside {CMD, HDR, DATA, CHK};
    tick = spi_on && div_q == DW'(SCK_DIV - 1);
    word_done = tick && sck_q && bit_q == 5'd31;
    word = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
    last = k_q == n_q - 1'b1;
    bad_len = word == 32'd0 || word > 32'(MAX_WORDS);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = CMD;
      CMD: state_d = word_done ? HDR : CMD;
      HDR: state_d = word_done ? (bad_len ? ERROR : DATA) : HDR;
      DATA: state_d = word_done ? AXI : DATA;
      AXI: state_d = (!aw_q || mem_awready_i) && (!w_q || mem_wready_i) ? RESP : AXI;
      RESP: state_d = !mem_bvalid_i ? RESP : mem_bresp_i != 2'b00 ? ERROR : last ? FIN : DATA;
`ifdef SPI_BOOT_CHECKSUM_EN
      CHK: state_d = word_done ? (word == sum_q ? DONE : ERROR) : CHK;
`endif
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state_q <= IDLE;
    else state_q <= state_d;
  // SCK toggles every SCK_DIV cycles; sample on rise, shift MOSI on fall
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      div_q <= '0;
      sck_q <= 1'b0;
      bit_q <= '0;
      tx_q <= {8'h03, FLASH_OFFSET};
      rx_q <= '0;
      n_q <= '0;
      k_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      aw_q <= 1'b0;
      w_q <= 1'b0;
    end else begin
      if (tick) begin
        div_q <= '0;
        sck_q <= !sck_q;
        if (!sck_q) rx_q <= {rx_q[30:0], spi_miso_i};
        else begin
          tx_q <= tx_q << 1;
          bit_q <= bit_q + 1'b1;
        end
      end else if (spi_on) div_q <= div_q + 1'b1;
      if (word_done && state_q == HDR) n_q <= word[CW-1:0];
      if (word_done && state_q == DATA) begin
        data_q <= word;
        addr_q <= TCM_BASE + (32'(k_q) << 2);
        aw_q <= 1'b1;
        w_q <= 1'b1;
      end
      if (aw_q && mem_awready_i) aw_q <= 1'b0;
      if (w_q && mem_wready_i) w_q <= 1'b0;
      if (state_q == RESP && mem_bvalid_i) k_q <= k_q + 1'b1;
    end
`ifdef SPI_BOOT_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) sum_q <= '0;
    else if (word_done && state_q == DATA) sum_q <= sum_q + word;
`endif
  always_comb begin
    spi_clk_o = sck_q;
    spi_cs_o = state_q inside {IDLE, DONE, ERROR};
    spi_mosi_o = state_q == CMD && tx_q[31];
    mem_awvalid_o = aw_q;
    mem_awaddr_o = addr_q;
    mem_awid_o = 4'h0;
    mem_awlen_o = 8'h00;
    mem_awburst_o = 2'b01;
    mem_wvalid_o = w_q;
    mem_wdata_o = data_q;
    mem_wstrb_o = 4'hF;
    mem_wlast_o = 1'b1;
    mem_bready_o = state_q == RESP;
    rst_cpu_o = state_q != DONE;
    done_o = state_q == DONE;
    error_o = state_q == ERROR;
  end
endmodule

// File: tb/tb_spi_boot_loader.sv
// tb_spi_boot_loader: flash and AXI slave models with a write scoreboard checked by a decoupled monitor.
module tb_spi_boot_loader;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic miso = 1'b0, sck, mosi, cs;
  logic awvalid, wvalid, bready, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] awaddr, wdata;
  logic [3:0] awid, wstrb;
  logic [7:0] awlen;
  logic [1:0] awburst, bresp = 2'b00;
  logic wlast, rst_cpu, done, error;

  spi_boot_loader dut (
    .clk_i(clk), .rst_i(rst_n), .spi_miso_i(miso), .spi_clk_o(sck), .spi_mosi_o(mosi), .spi_cs_o(cs),
    .mem_awvalid_o(awvalid), .mem_awaddr_o(awaddr), .mem_awid_o(awid), .mem_awlen_o(awlen),
    .mem_awburst_o(awburst), .mem_wvalid_o(wvalid), .mem_wdata_o(wdata), .mem_wstrb_o(wstrb),
    .mem_wlast_o(wlast), .mem_bready_o(bready), .mem_awready_i(awready), .mem_wready_i(wready),
    .mem_bvalid_i(bvalid), .mem_bresp_i(bresp), .rst_cpu_o(rst_cpu), .done_o(done), .error_o(error)
  );

  int checks = 0, fails = 0;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  logic [31:0] img [0:63];
  int aw_delay = 0, w_delay = 0, b_delay = 0, err_word = 99;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flash: counts SCK rises while selected; first 32 are the command, then streams img LSB byte first
  int sck_cnt = 0, fd;
  logic prev_sck = 1'b0;
  logic [31:0] cmd_bits = '0, cmd_seen = '0;
  always @(negedge clk) begin
    if (!rst_n) cmd_seen = '0;
    if (cs) begin
      sck_cnt = 0;
      miso = 1'b0;
      cmd_bits = '0;
    end else if (sck && !prev_sck) begin
      if (sck_cnt < 32) cmd_bits = {cmd_bits[30:0], mosi};
      sck_cnt++;
      if (sck_cnt == 32) cmd_seen = cmd_bits;
    end else if (!sck && prev_sck && sck_cnt >= 32) begin
      fd = sck_cnt - 32;
      miso = fd / 32 < 64 ? img[fd / 32][8 * ((fd / 8) % 4) + 7 - fd % 8] : 1'b0;
    end
    prev_sck = sck;
  end

  // AXI slave with per-channel ready delays and an injectable error response
  int aw_wait = 0, w_wait = 0, b_wait = 0, widx = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      aw_wait = 0; w_wait = 0; b_wait = 0; widx = 0;
    end else begin
      awready = awvalid && aw_wait >= aw_delay;
      aw_wait = awvalid ? aw_wait + 1 : 0;
      wready = wvalid && w_wait >= w_delay;
      w_wait = wvalid ? w_wait + 1 : 0;
      if (bready) begin
        bvalid = b_wait >= b_delay;
        bresp = widx == err_word ? 2'b10 : 2'b00;
        b_wait++;
      end else begin
        if (bvalid) widx++;
        bvalid = 1'b0;
        b_wait = 0;
      end
    end
  end

  // Monitor: pairs each AW handshake with its W handshake and pops the scoreboard
  bit have_aw = 0, have_w = 0;
  logic [31:0] got_addr, got_data;
  wr_t e;
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      have_aw = 0;
      have_w = 0;
    end else begin
      if (awvalid || wvalid || bready) chk("sck_stall", {31'd0, sck}, 32'd0);
      if (awvalid && awready) begin
        if (have_aw) chk("dup_aw", 32'd1, 32'd0);
        have_aw = 1;
        got_addr = awaddr;
        chk("aw_consts", {awid, awlen, awburst}, {4'h0, 8'h00, 2'b01});
      end
      if (wvalid && wready) begin
        if (have_w) chk("dup_w", 32'd1, 32'd0);
        have_w = 1;
        got_data = wdata;
        chk("w_consts", {wstrb, wlast}, {4'hF, 1'b1});
      end
      if (have_aw && have_w) begin
        have_aw = 0;
        have_w = 0;
        if (exp_q.size() == 0) chk("unexpected_write", got_addr, 32'hFFFFFFFF);
        else begin
          e = exp_q.pop_front();
          chk("awaddr", got_addr, e.addr);
          chk("wdata", got_data, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] sum_of(input int n);
    logic [31:0] s = '0;
    for (int k = 0; k < n; k++) s += img[k + 1];
    return s;
  endfunction

  // Reference model: which writes occur and whether the copy ends in error
  task automatic expect_all(output bit exp_err);
    int n;
    exp_q.delete();
    if (img[0] == 32'd0 || img[0] > 32'd4096) exp_err = 1;
    else begin
      n = int'(img[0]);
      for (int k = 0; k < n && k <= err_word; k++) exp_q.push_back('{32'(k * 4), img[k + 1]});
      exp_err = err_word < n;
`ifdef SPI_BOOT_CHECKSUM_EN
      if (!exp_err && img[n + 1] != sum_of(n)) exp_err = 1;
`endif
    end
  endtask

  task automatic check_reset(input string name);
    chk(name, {23'd0, cs, sck, mosi, awvalid, wvalid, bready, rst_cpu, done, error},
        {23'd0, 9'b1_0_0_0_0_0_1_0_0});
  endtask

  task automatic run(input int awd, input int wd, input int bd, input int ew, input bit mid);
    bit exp_err;
    int cyc;
    rst_n = 1'b0;
    #1;
    check_reset("reset_values");
    aw_delay = awd; w_delay = wd; b_delay = bd; err_word = ew;
    expect_all(exp_err);
    repeat (3) @(negedge clk);
    if (mid) begin
      rst_n = 1'b1;
      cyc = 0;
      while (widx < 1 && cyc < 5000) begin @(negedge clk); cyc++; end
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset("mid_reset_values");
      expect_all(exp_err);
      repeat (3) @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("cs_low_after_release", {31'd0, cs}, 32'd0);
    cyc = 0;
    while (!(done || error) && cyc < 20000) begin @(negedge clk); cyc++; end
    if (cyc >= 20000) chk("timeout", 32'(cyc), 32'd0);
    repeat (10) @(negedge clk);
    chk("done", {31'd0, done}, {31'd0, !exp_err});
    chk("error", {31'd0, error}, {31'd0, exp_err});
    chk("rst_cpu", {31'd0, rst_cpu}, {31'd0, exp_err});
    chk("cs_idle", {31'd0, cs}, 32'd1);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    chk("cmd", cmd_seen, 32'h03100000);
  endtask

  task automatic load_fixed();
    img[0] = 32'd3;
    img[1] = 32'h11223344;
    img[2] = 32'h55667788;
    img[3] = 32'h99AABBCC;
    img[4] = sum_of(3);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) img[i] = '0;
    load_fixed();
    run(0, 0, 0, 99, 0);
    run(5, 0, 1, 99, 0);
    run(0, 5, 2, 99, 0);
    img[0] = 32'd0;
    run(0, 0, 0, 99, 0);
    img[0] = 32'd4097;
    run(0, 0, 0, 99, 0);
    load_fixed();
    run(0, 0, 0, 1, 0);
    run(1, 1, 1, 99, 1);
    img[4] = 32'd0;
    run(0, 0, 0, 99, 0);
    img[4] = 32'hAAAAAAAB;
    run(2, 3, 0, 99, 0);
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 8);
      img[0] = 32'(n);
      for (int k = 1; k <= n; k++) img[k] = $urandom;
      img[n + 1] = $urandom_range(0, 1) ? sum_of(n) : sum_of(n) ^ 32'h00010000;
      run($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 12), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
